wave_cmd_controller: RTL and testbench

- Command sequencer between the UART byte receiver and the waveform generator datapath.
- Parses single- and two-byte ASCII commands into a staged configuration: wave type, frequency select and white-noise enable.
- Commits the staged configuration to the generator only at a waveform period boundary, so waveforms never glitch.
- Returns a one-byte ACK/NAK to the UART transmitter over a valid/ready handshake.

---
 rtl/wave_cmd_controller.sv | 144 ++++++++++++++
 tb/tb_wave_cmd_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wave_cmd_controller.sv
// wave_cmd_controller: parses UART ASCII commands into a staged waveform config,
// commits it to the generator on a period boundary, and answers each command with 'K'/'E'.
//   in : clk, rst (async active-high), rx_data/rx_valid (UART bytes), phase_wrap (period end),
//        ack_ready (transmitter accepts response)
//   out: wave_select, freq_select, white_noise_en (committed config), cfg_update (commit pulse),
//        cfg_pending (staged != committed), ack_data/ack_valid (response), ack_overrun (sticky)
module wave_cmd_controller #(
    parameter int TIMEOUT_CYCLES = 250000,
    parameter bit SYNC_APPLY     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       phase_wrap,
    output logic [2:0] wave_select,
    output logic [2:0] freq_select,
    output logic       white_noise_en,
    output logic       cfg_update,
    output logic       cfg_pending,
    output logic [7:0] ack_data,
    output logic       ack_valid,
    input  logic       ack_ready,
    output logic       ack_overrun
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] ACK_K = 8'h4B;
    localparam logic [7:0] ACK_E = 8'h45;

    typedef enum logic [1:0] {IDLE, WAIT_FREQ, WAIT_NOISE} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] sw_q, sw_d, sf_q, sf_d, cw_q, cw_d, cf_q, cf_d;
    logic sn_q, sn_d, cn_q, cn_d;
    logic upd_q, upd_d, av_q, av_d, ovr_q, ovr_d;
    logic [7:0] ad_q, ad_d;
    logic resolve, stg_diff, commit;
    logic [7:0] resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sw_q    <= '0;
            sf_q    <= '0;
            sn_q    <= 1'b0;
            cw_q    <= '0;
            cf_q    <= '0;
            cn_q    <= 1'b0;
            upd_q   <= 1'b0;
            av_q    <= 1'b0;
            ad_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            sf_q    <= sf_d;
            sn_q    <= sn_d;
            cw_q    <= cw_d;
            cf_q    <= cf_d;
            cn_q    <= cn_d;
            upd_q   <= upd_d;
            av_q    <= av_d;
            ad_q    <= ad_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        sf_d    = sf_q;
        sn_d    = sn_q;
        resolve = 1'b0;
        resp    = ACK_K;
        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    resolve = 1'b1;
                    case (rx_data)
                        8'h54: sw_d = 3'd0;
                        8'h53: sw_d = 3'd1;
                        8'h51: sw_d = 3'd2;
                        8'h49: sw_d = 3'd3;
                        8'h46: begin
                            state_d = WAIT_FREQ;
                            cnt_d   = '0;
                            resolve = 1'b0;
                        end
                        8'h57: begin
                            state_d = WAIT_NOISE;
                            cnt_d   = '0;
                            resolve = 1'b0;
                        end
                        default: resp = ACK_E;
                    endcase
                end
                WAIT_FREQ: begin
                    state_d = IDLE;
                    resolve = 1'b1;
                    if (rx_data inside {[8'h30:8'h37]}) sf_d = rx_data[2:0];
                    else resp = ACK_E;
                end
                WAIT_NOISE: begin
                    state_d = IDLE;
                    resolve = 1'b1;
                    if (rx_data inside {8'h30, 8'h31}) sn_d = rx_data[0];
                    else resp = ACK_E;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                resolve = 1'b1;
                resp    = ACK_E;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Commit reads the staged registers, so a byte staged this same cycle waits for the next wrap.
        stg_diff = {sw_q, sf_q, sn_q} != {cw_q, cf_q, cn_q};
        commit   = stg_diff && (phase_wrap || !SYNC_APPLY);
        cw_d     = commit ? sw_q : cw_q;
        cf_d     = commit ? sf_q : cf_q;
        cn_d     = commit ? sn_q : cn_q;
        upd_d    = commit;
        av_d     = resolve || (av_q && !ack_ready);
        ad_d     = resolve ? resp : ad_q;
        ovr_d    = ovr_q || (resolve && av_q && !ack_ready);
    end

    assign wave_select    = cw_q;
    assign freq_select    = cf_q;
    assign white_noise_en = cn_q;
    assign cfg_update     = upd_q;
    assign cfg_pending    = stg_diff;
    assign ack_data       = ad_q;
    assign ack_valid      = av_q;
    assign ack_overrun    = ovr_q;
endmodule

// File: tb/tb_wave_cmd_controller.sv
// tb_wave_cmd_controller: scoreboard bench for wave_cmd_controller with a command-level reference model.
module tb_wave_cmd_controller;
    localparam int TO = 100;
    localparam logic [7:0] K = 8'h4B;
    localparam logic [7:0] E = 8'h45;

    logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, phase_wrap = 1'b0, ack_ready = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic [2:0] wave_select, freq_select;
    logic white_noise_en, cfg_update, cfg_pending, ack_valid, ack_overrun;
    logic [7:0] ack_data;

    wave_cmd_controller #(.TIMEOUT_CYCLES(TO), .SYNC_APPLY(1'b1)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .phase_wrap(phase_wrap),
        .wave_select(wave_select), .freq_select(freq_select), .white_noise_en(white_noise_en),
        .cfg_update(cfg_update), .cfg_pending(cfg_pending), .ack_data(ack_data),
        .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_overrun(ack_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [2:0] w; logic [2:0] f; logic n;} cfg_t;
    cfg_t stg, com;
    cfg_t cfg_q[$];
    logic [7:0] ack_q[$];
    logic slot_full, m_ovr, resolved, acc_now;
    logic [7:0] partial;
    int gap;
    int n_cmp = 0, n_bad = 0;
    logic [7:0] pool[16] = '{"T", "S", "Q", "I", "F", "W", "0", "1", "2", "5", "7", "8", "9", "x", "t", "F"};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        stg = '0; com = '0; cfg_q.delete(); ack_q.delete();
        slot_full = 1'b0; m_ovr = 1'b0; partial = 8'h00; gap = 0;
    endtask

    // A response produced while the previous one still sits unaccepted replaces it.
    task automatic respond(input logic [7:0] r);
        if (slot_full && !acc_now && ack_q.size() > 0) begin
            ack_q[ack_q.size()-1] = r;
            m_ovr = 1'b1;
        end else ack_q.push_back(r);
        resolved = 1'b1;
    endtask

    task automatic process_byte(input logic [7:0] d);
        if (partial == "F") begin
            partial = 8'h00;
            if (d >= "0" && d <= "7") begin stg.f = d[2:0]; respond(K); end
            else respond(E);
        end else if (partial == "W") begin
            partial = 8'h00;
            if (d == "0" || d == "1") begin stg.n = (d == "1"); respond(K); end
            else respond(E);
        end else begin
            case (d)
                "T": begin stg.w = 3'd0; respond(K); end
                "S": begin stg.w = 3'd1; respond(K); end
                "Q": begin stg.w = 3'd2; respond(K); end
                "I": begin stg.w = 3'd3; respond(K); end
                "F", "W": begin partial = d; gap = 0; end
                default: respond(E);
            endcase
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input logic w);
        rx_valid = v; rx_data = d; phase_wrap = w;
        acc_now = slot_full && ack_ready;
        resolved = 1'b0;
        if (w && stg != com) begin cfg_q.push_back(stg); com = stg; end
        if (v) process_byte(d);
        else if (partial != 8'h00) begin
            gap++;
            if (gap == TO) begin partial = 8'h00; respond(E); end
        end
        slot_full = resolved || (slot_full && !acc_now);
        @(posedge clk); #1;
        rx_valid = 1'b0; phase_wrap = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wave"}, wave_select, 0);
        chk({tag, "_freq"}, freq_select, 0);
        chk({tag, "_noise"}, white_noise_en, 0);
        chk({tag, "_upd"}, cfg_update, 0);
        chk({tag, "_pend"}, cfg_pending, 0);
        chk({tag, "_ackv"}, ack_valid, 0);
        chk({tag, "_ackd"}, ack_data, 0);
        chk({tag, "_ovr"}, ack_overrun, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ack_valid && ack_ready) begin
                    if (ack_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL ack_unexpected: got %h expected none", ack_data);
                    end else chk("ack_byte", ack_data, ack_q.pop_front());
                end
                if (cfg_update) begin
                    if (cfg_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL commit_unexpected: got %h expected none", {wave_select, freq_select, white_noise_en});
                    end else chk("commit", {wave_select, freq_select, white_noise_en}, cfg_q.pop_front());
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        tick(1'b1, "T", 1'b0);
        chk("t_pend", cfg_pending, 0);
        chk("t_ack_lat", ack_valid, 1);
        tick(1'b0, 8'h00, 1'b1);
        chk("t_wave", wave_select, 0);
        chk("t_noupd", cfg_update, 0);
        idle(2);
        tick(1'b1, "S", 1'b0);
        idle(1000);
        chk("s_hold_wave", wave_select, 0);
        chk("s_hold_pend", cfg_pending, 1);
        tick(1'b0, 8'h00, 1'b1);
        chk("s_wave", wave_select, 1);
        chk("s_upd", cfg_update, 1);
        chk("s_pend", cfg_pending, 0);
        idle(1);
        chk("s_upd_once", cfg_update, 0);
        tick(1'b1, "F", 1'b0);
        tick(1'b1, "5", 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        chk("f5_freq", freq_select, 5);
        tick(1'b1, "F", 1'b0);
        tick(1'b1, "9", 1'b0);
        chk("f9_ack", ack_data, E);
        chk("f9_freq", freq_select, 5);
        chk("f9_pend", cfg_pending, 0);
        tick(1'b1, "W", 1'b0);
        idle(TO - 1);
        chk("to_early", ack_valid, 0);
        idle(1);
        chk("to_ackv", ack_valid, 1);
        chk("to_ackd", ack_data, E);
        tick(1'b1, "Q", 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        chk("q_wave", wave_select, 2);
        tick(1'b1, "S", 1'b0);
        tick(1'b1, "I", 1'b1);
        chk("sim_wave", wave_select, 1);
        chk("sim_pend", cfg_pending, 1);
        chk("sim_upd", cfg_update, 1);
        tick(1'b0, 8'h00, 1'b1);
        chk("sim_wave2", wave_select, 3);
        idle(2);
        ack_ready = 1'b0;
        tick(1'b1, "T", 1'b0);
        tick(1'b1, "x", 1'b0);
        chk("ovr_ackv", ack_valid, 1);
        chk("ovr_ackd", ack_data, E);
        chk("ovr_flag", ack_overrun, 1);
        ack_ready = 1'b1;
        idle(1);
        chk("ovr_drop", ack_valid, 0);
        chk("ovr_sticky", ack_overrun, 1);
        tick(1'b1, "F", 1'b0);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1'b1, "5", 1'b0);
        chk("post_rst_ack", ack_data, E);
        idle(2);
        for (int i = 0; i < 400; i++) begin
            ack_ready = ($urandom_range(0, 3) != 0);
            tick(1'b1, pool[$urandom_range(0, 15)], $urandom_range(0, 3) == 0);
            chk("rnd_pend", cfg_pending, stg != com);
            repeat ($urandom_range(0, 2)) begin
                ack_ready = ($urandom_range(0, 3) != 0);
                tick(1'b0, 8'h00, $urandom_range(0, 3) == 0);
            end
        end
        ack_ready = 1'b1;
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        idle(3);
        chk("end_ackq", ack_q.size(), 0);
        chk("end_cfgq", cfg_q.size(), 0);
        chk("end_ovr", ack_overrun, m_ovr);
        chk("end_cfg", {wave_select, freq_select, white_noise_en}, com);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
